hazard_unit: RTL

//  Pipeline hazard/control generator: drives load-enable and flush of the IF/ID and ID/EX registers and the PC.

---
 rtl/hazard_unit.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard/control generator for a classic 5-stage pipeline. It drives
//   the load enables and flushes of the PC, IF/ID and ID/EX registers. It
//   detects load-use hazards, branch/jump redirects and syscall halt, and it
//   produces the EX operand forwarding selects. It also counts stall and
//   redirect events for the performance display.
//
// Parameters
//   LD_STALL  bubble cycles inserted per load-use hazard (>= 1)
//   CNT_BITS  width of stall_cnt / flush_cnt (both saturate at all-ones)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_r{1,2}_num/used  ID-stage instruction and its source operands
//   ex_valid, ex_ld, ex_regwrite,
//   ex_write, ex_r{1,2}_num       ID/EX register outputs
//   mem_regwrite, mem_write       EX/MEM destination
//   wb_regwrite, wb_write         MEM/WB destination
//   ex_redirect, ex_halt, resume  redirect / halt / release-halt events
//   pc_en, if_id_en, id_ex_en     register load enables
//   if_id_zero, id_ex_zero        register flushes
//   fwd_a_sel, fwd_b_sel          00 regfile, 01 EX/MEM, 10 MEM/WB
//   halted                        1 while in HALT
//   stall_cnt, flush_cnt          saturating event counters
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int LD_STALL = 1,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [5:0]          id_r1_num,
    input  logic                id_r1_used,
    input  logic [5:0]          id_r2_num,
    input  logic                id_r2_used,
    input  logic                ex_valid,
    input  logic                ex_ld,
    input  logic                ex_regwrite,
    input  logic [5:0]          ex_write,
    input  logic [5:0]          ex_r1_num,
    input  logic [5:0]          ex_r2_num,
    input  logic                mem_regwrite,
    input  logic [5:0]          mem_write,
    input  logic                wb_regwrite,
    input  logic [5:0]          wb_write,
    input  logic                ex_redirect,
    input  logic                ex_halt,
    input  logic                resume,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                if_id_zero,
    output logic                id_ex_en,
    output logic                id_ex_zero,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] flush_cnt
);

    // The bubble counter only has to hold LD_STALL-1 (the remaining bubbles
    // after the first one, which is issued from RUN).
    localparam int BUB_W = (LD_STALL > 1) ? $clog2(LD_STALL) : 1;
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(LD_STALL - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [BUB_W-1:0]      bub_cnt_reg;
    logic [BUB_W-1:0]      bub_cnt_next;
    logic [CNT_BITS-1:0]   stall_cnt_reg;
    logic [CNT_BITS-1:0]   flush_cnt_reg;
    logic                  stall_inc;
    logic                  flush_inc;

    // ------------------------------------------------------------------
    // Load-use detection: one comparator per ID source operand.
    // ------------------------------------------------------------------
    logic [5:0] id_src_num  [2];
    logic       id_src_used [2];
    logic       id_src_hit  [2];

    assign id_src_num[0]  = id_r1_num;
    assign id_src_num[1]  = id_r2_num;
    assign id_src_used[0] = id_r1_used;
    assign id_src_used[1] = id_r2_used;

    logic ex_load_dest;
    // Register 0 is hard-wired zero, so a load targeting it never hazards.
    assign ex_load_dest = ex_valid && ex_ld && ex_regwrite && (ex_write != 6'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lu
            assign id_src_hit[gi] = id_src_used[gi] && (id_src_num[gi] == ex_write);
        end
    endgenerate

    logic lu_hit;
    assign lu_hit = id_valid && ex_load_dest && (id_src_hit[0] || id_src_hit[1]);

    // ------------------------------------------------------------------
    // Forwarding: EX/MEM is younger than MEM/WB, so it takes precedence.
    // ------------------------------------------------------------------
    logic [5:0] ex_src_num [2];
    logic [1:0] fwd_raw    [2];

    assign ex_src_num[0] = ex_r1_num;
    assign ex_src_num[1] = ex_r2_num;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_match;
            logic wb_match;
            assign mem_match = mem_regwrite && (mem_write != 6'd0) &&
                               (mem_write == ex_src_num[gi]);
            assign wb_match  = wb_regwrite && (wb_write != 6'd0) &&
                               (wb_write == ex_src_num[gi]);
            assign fwd_raw[gi] = mem_match ? 2'b01 :
                                 wb_match  ? 2'b10 : 2'b00;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control decode. Outputs are combinational from state + inputs so the
    // pipeline registers react in the same cycle the hazard is seen.
    // Priority in RUN: halt > redirect > load-use.
    // ------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_zero   = 1'b0;
        id_ex_zero   = 1'b0;
        fwd_a_sel    = fwd_raw[0];
        fwd_b_sel    = fwd_raw[1];
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_next   = state_reg;
        bub_cnt_next = bub_cnt_reg;

        case (state_reg)
            ST_RUN: begin
                if (ex_valid && ex_halt) begin
                    // Freeze everything; the halting instruction stays in EX.
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_ex_en   = 1'b0;
                    state_next = ST_HALT;
                end else if (ex_redirect) begin
                    // Squash the two wrong-path instructions behind EX.
                    if_id_zero = 1'b1;
                    id_ex_zero = 1'b1;
                    flush_inc  = 1'b1;
                end else if (lu_hit) begin
                    // Hold PC and IF/ID, insert a bubble into ID/EX.
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_ex_zero = 1'b1;
                    stall_inc  = 1'b1;
                    if (LD_STALL > 1) begin
                        state_next   = ST_LDUSE;
                        bub_cnt_next = BUB_LOAD;
                    end
                end
            end

            ST_LDUSE: begin
                // EX holds a bubble here, so redirect/halt cannot occur.
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                id_ex_zero = 1'b1;
                stall_inc  = 1'b1;
                if (bub_cnt_reg <= BUB_W'(1)) begin
                    state_next   = ST_RUN;
                    bub_cnt_next = '0;
                end else begin
                    bub_cnt_next = bub_cnt_reg - BUB_W'(1);
                end
            end

            ST_HALT: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                if (resume) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next   = ST_RUN;
                bub_cnt_next = '0;
            end
        endcase

        // During reset the pipeline is held empty regardless of state.
        if (rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            if_id_zero = 1'b1;
            id_ex_zero = 1'b1;
            fwd_a_sel  = 2'b00;
            fwd_b_sel  = 2'b00;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and saturating counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            bub_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bub_cnt_reg <= bub_cnt_next;
            if (stall_inc && (stall_cnt_reg != {CNT_BITS{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_BITS'(1);
            end
            if (flush_inc && (flush_cnt_reg != {CNT_BITS{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_BITS'(1);
            end
        end
    end

    assign halted    = (state_reg == ST_HALT);
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule
